// File: rtl/uc_multiciclo_if.sv
// Instruction/data memory request-acknowledge handshake between the polirv control unit and its memories.
interface uc_multiciclo_if;
  logic i_mem_req;
  logic i_mem_ack;
  logic d_mem_req;
  logic d_mem_we;
  logic d_mem_ack;

  modport master (
    output i_mem_req,
    output d_mem_req,
    output d_mem_we,
    input  i_mem_ack,
    input  d_mem_ack
  );

  modport slave (
    input  i_mem_req,
    input  d_mem_req,
    input  d_mem_we,
    output i_mem_ack,
    output d_mem_ack
  );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the polirv core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshakes with a watchdog, an absorbing trap state and a retired-instruction counter.
module uc_multiciclo #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic [3:0]         alu_flags,
  uc_multiciclo_if.master    mem,
  output logic               ir_we,
  output logic               pc_we,
  output logic               pc_src,
  output logic               alu_src,
  output logic               rf_src,
  output logic               rf_we,
  output logic [3:0]         alu_cmd,
  output logic               trap,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           r_state;
  logic [TO_W-1:0]  r_wdog;
  logic [CNT_W-1:0] r_instret;

  state_t     w_next;
  logic       w_i_req, w_d_req, w_d_we;
  logic       w_ir_we, w_pc_we, w_pc_src, w_alu_src, w_rf_src, w_rf_we, w_trap;
  logic [3:0] w_alu_cmd;
  logic       w_retire, w_illegal, w_taken, w_timeout;
  logic       w_req_any, w_ack_any;
  logic       w_z, w_n, w_v;
  logic       w_unused_carry;

  assign w_z            = alu_flags[0];
  assign w_n            = alu_flags[1];
  assign w_v            = alu_flags[3];
  assign w_unused_carry = alu_flags[2];
  assign w_timeout      = (r_wdog == TO_W'(TIMEOUT - 1));

  // Next-state and raw control decode from state, IR fields and ALU flags.
  always_comb begin
    w_next    = r_state;
    w_i_req   = 1'b0;
    w_d_req   = 1'b0;
    w_d_we    = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_pc_src  = 1'b0;
    w_alu_src = 1'b0;
    w_rf_src  = 1'b0;
    w_rf_we   = 1'b0;
    w_alu_cmd = ALU_ADD;
    w_trap    = 1'b0;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    w_taken   = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_i_req = 1'b1;
        if (mem.i_mem_ack) begin
          w_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
        end
      end

      S_DECODE: begin
        case (opcode)
          OPC_LD, OPC_SD, OPC_OP, OPC_IMM, OPC_BR: w_next = S_EXEC;
          default:                                 w_next = S_TRAP;
        endcase
      end

      S_EXEC: begin
        case (opcode)
          OPC_OP, OPC_IMM: begin
            w_alu_src = (opcode == OPC_IMM);
            case (funct3)
              3'b000:  w_alu_cmd = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
              3'b111:  w_alu_cmd = ALU_AND;
              3'b110:  w_alu_cmd = ALU_OR;
              default: w_illegal = 1'b1;
            endcase
            w_next = w_illegal ? S_TRAP : S_WB;
          end
          OPC_LD, OPC_SD: begin
            w_alu_src = 1'b1;
            w_next    = (funct3 == 3'b011) ? S_MEM : S_TRAP;
          end
          OPC_BR: begin
            w_alu_cmd = ALU_SUB;
            case (funct3)
              3'b000:  w_taken = w_z;
              3'b001:  w_taken = !w_z;
              3'b100:  w_taken = w_n ^ w_v;
              3'b101:  w_taken = !(w_n ^ w_v);
              default: w_illegal = 1'b1;
            endcase
            if (w_illegal) begin
              w_next = S_TRAP;
            end else begin
              w_pc_we  = 1'b1;
              w_pc_src = w_taken;
              w_retire = 1'b1;
              w_next   = S_FETCH;
            end
          end
          default: w_next = S_TRAP;
        endcase
      end

      S_MEM: begin
        w_d_req = 1'b1;
        w_d_we  = (opcode == OPC_SD);
        if (mem.d_mem_ack) begin
          if (opcode == OPC_SD) begin
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next   = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end

      S_WB: begin
        w_rf_we  = 1'b1;
        w_rf_src = (opcode == OPC_LD);
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end

      S_TRAP: w_trap = 1'b1;

      default: w_next = S_FETCH;
    endcase
  end

  assign w_req_any = w_i_req | w_d_req;
  assign w_ack_any = (w_i_req & mem.i_mem_ack) | (w_d_req & mem.d_mem_ack);

  // State, watchdog and retire counter; the watchdog only runs while a request is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wdog    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_req_any && !w_ack_any)
        r_wdog <= r_wdog + TO_W'(1);
      else
        r_wdog <= '0;
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Every output is forced low while reset is held, including any in-flight request.
  assign mem.i_mem_req = rst ? 1'b0 : w_i_req;
  assign mem.d_mem_req = rst ? 1'b0 : w_d_req;
  assign mem.d_mem_we  = rst ? 1'b0 : w_d_we;
  assign ir_we         = rst ? 1'b0 : w_ir_we;
  assign pc_we         = rst ? 1'b0 : w_pc_we;
  assign pc_src        = rst ? 1'b0 : w_pc_src;
  assign alu_src       = rst ? 1'b0 : w_alu_src;
  assign rf_src        = rst ? 1'b0 : w_rf_src;
  assign rf_we         = rst ? 1'b0 : w_rf_we;
  assign alu_cmd       = rst ? ALU_ADD : w_alu_cmd;
  assign trap          = rst ? 1'b0 : w_trap;
  assign instret       = rst ? '0 : r_instret;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed self-checking bench for uc_multiciclo: instruction classes, memory wait states,
// branch conditions, illegal opcode trap, watchdog timeout and reset mid-access.
module tb_uc_multiciclo;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [3:0]  alu_flags;
  logic        ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, trap;
  logic [3:0]  alu_cmd;
  logic [31:0] instret;

  int n_vec;
  int n_err;
  int exp_ret;

  uc_multiciclo_if mif ();

  uc_multiciclo #(.TIMEOUT(15), .TO_W(4), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .alu_flags (alu_flags),
    .mem       (mif.master),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_src   (alu_src),
    .rf_src    (rf_src),
    .rf_we     (rf_we),
    .alu_cmd   (alu_cmd),
    .trap      (trap),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {i_req,d_req,d_we,ir_we,pc_we,pc_src,alu_src,rf_src,rf_we,trap,alu_cmd[3:0]}
  localparam logic [13:0] C_IDLE    = 14'b0_0_0_0_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_F_ACK   = 14'b1_0_0_1_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_F_WAIT  = 14'b1_0_0_0_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_EX_ADD  = 14'b0_0_0_0_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_EX_SUB  = 14'b0_0_0_0_0_0_0_0_0_0_0001;
  localparam logic [13:0] C_EX_AND  = 14'b0_0_0_0_0_0_0_0_0_0_0010;
  localparam logic [13:0] C_EX_ORI  = 14'b0_0_0_0_0_0_1_0_0_0_0011;
  localparam logic [13:0] C_EX_ADDI = 14'b0_0_0_0_0_0_1_0_0_0_0000;
  localparam logic [13:0] C_EX_MEM  = 14'b0_0_0_0_0_0_1_0_0_0_0000;
  localparam logic [13:0] C_WB_ALU  = 14'b0_0_0_0_1_0_0_0_1_0_0000;
  localparam logic [13:0] C_WB_LD   = 14'b0_0_0_0_1_0_0_1_1_0_0000;
  localparam logic [13:0] C_MEM_LD  = 14'b0_1_0_0_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_MEM_SDW = 14'b0_1_1_0_0_0_0_0_0_0_0000;
  localparam logic [13:0] C_MEM_SDA = 14'b0_1_1_0_1_0_0_0_0_0_0000;
  localparam logic [13:0] C_BR_T    = 14'b0_0_0_0_1_1_0_0_0_0_0001;
  localparam logic [13:0] C_BR_NT   = 14'b0_0_0_0_1_0_0_0_0_0_0001;
  localparam logic [13:0] C_TRAP    = 14'b0_0_0_0_0_0_0_0_0_1_0000;

  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  function automatic logic [13:0] ctl();
    return {mif.i_mem_req, mif.d_mem_req, mif.d_mem_we, ir_we, pc_we, pc_src,
            alu_src, rf_src, rf_we, trap, alu_cmd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait OP/OP-IMM instruction: FETCH, DECODE, EXEC, WB.
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [13:0] e_exec);
    opcode = op; funct3 = f3; funct7_5 = f7;
    mif.i_mem_ack = 1'b1; mif.d_mem_ack = 1'b0;
    #1;
    chk({tag, "/fetch"}, 32'(ctl()), 32'(C_F_ACK));
    step();
    chk({tag, "/decode"}, 32'(ctl()), 32'(C_IDLE));
    step();
    chk({tag, "/exec"}, 32'(ctl()), 32'(e_exec));
    step();
    chk({tag, "/wb"}, 32'(ctl()), 32'(C_WB_ALU));
    chk({tag, "/instret_pre"}, instret, 32'(exp_ret));
    step();
    exp_ret++;
    chk({tag, "/instret"}, instret, 32'(exp_ret));
  endtask

  // Zero-wait branch: FETCH, DECODE, EXEC then back to FETCH.
  task automatic run_br(input string tag, input logic [2:0] f3, input logic [3:0] flags,
                        input logic [13:0] e_exec);
    opcode = OPC_BR; funct3 = f3; funct7_5 = 1'b0; alu_flags = flags;
    mif.i_mem_ack = 1'b1; mif.d_mem_ack = 1'b0;
    #1;
    chk({tag, "/fetch"}, 32'(ctl()), 32'(C_F_ACK));
    step();
    step();
    chk({tag, "/exec"}, 32'(ctl()), 32'(e_exec));
    step();
    exp_ret++;
    chk({tag, "/instret"}, instret, 32'(exp_ret));
    chk({tag, "/refetch"}, 32'(ctl()), 32'(C_F_ACK));
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_ret = 0;
    rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; alu_flags = '0;
    mif.i_mem_ack = 1'b0; mif.d_mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs held low under reset even with acks asserted.
    mif.i_mem_ack = 1'b1; mif.d_mem_ack = 1'b1;
    #1;
    chk("reset/ctl", 32'(ctl()), 32'(C_IDLE));
    chk("reset/instret", instret, 32'd0);
    rst = 1'b0;

    run_alu("op_add",  OPC_OP,  3'b000, 1'b0, C_EX_ADD);
    run_alu("op_sub",  OPC_OP,  3'b000, 1'b1, C_EX_SUB);
    run_alu("op_and",  OPC_OP,  3'b111, 1'b0, C_EX_AND);
    run_alu("imm_or",  OPC_IMM, 3'b110, 1'b0, C_EX_ORI);
    run_alu("imm_add", OPC_IMM, 3'b000, 1'b1, C_EX_ADDI);

    // LD with three wait states on the data port: 8 cycles in total.
    opcode = OPC_LD; funct3 = 3'b011; mif.i_mem_ack = 1'b1; mif.d_mem_ack = 1'b0;
    #1;
    chk("ld/fetch", 32'(ctl()), 32'(C_F_ACK));
    step();
    chk("ld/decode", 32'(ctl()), 32'(C_IDLE));
    step();
    chk("ld/exec", 32'(ctl()), 32'(C_EX_MEM));
    step();
    for (int k = 0; k < 4; k++) begin
      mif.d_mem_ack = (k == 3);
      #1;
      chk($sformatf("ld/mem%0d", k), 32'(ctl()), 32'(C_MEM_LD));
      step();
    end
    mif.d_mem_ack = 1'b0;
    #1;
    chk("ld/wb", 32'(ctl()), 32'(C_WB_LD));
    step();
    exp_ret++;
    chk("ld/instret", instret, 32'(exp_ret));

    // SD zero-wait: retires from MEM in 4 cycles.
    opcode = OPC_SD; funct3 = 3'b011; mif.d_mem_ack = 1'b1;
    #1;
    chk("sd/fetch", 32'(ctl()), 32'(C_F_ACK));
    step();
    step();
    chk("sd/exec", 32'(ctl()), 32'(C_EX_MEM));
    step();
    chk("sd/mem", 32'(ctl()), 32'(C_MEM_SDA));
    step();
    exp_ret++;
    chk("sd/instret", instret, 32'(exp_ret));
    chk("sd/refetch", 32'(ctl()), 32'(C_F_ACK));

    run_br("beq_z1",  3'b000, 4'b0001, C_BR_T);
    run_br("blt_nv",  3'b100, 4'b1010, C_BR_NT);
    run_br("bne_z0",  3'b001, 4'b0000, C_BR_T);
    run_br("bge_n1",  3'b101, 4'b0010, C_BR_NT);

    // Reset while an SD is stalled in MEM: request drops at once, ack is ignored.
    opcode = OPC_SD; funct3 = 3'b011; mif.i_mem_ack = 1'b1; mif.d_mem_ack = 1'b0;
    step();
    step();
    step();
    chk("rstmem/mem", 32'(ctl()), 32'(C_MEM_SDW));
    rst = 1'b1; mif.d_mem_ack = 1'b1;
    #1;
    chk("rstmem/drop", 32'(ctl()), 32'(C_IDLE));
    step();
    rst = 1'b0; mif.i_mem_ack = 1'b0; mif.d_mem_ack = 1'b0;
    exp_ret = 0;
    #1;
    chk("rstmem/fetch", 32'(ctl()), 32'(C_F_WAIT));
    chk("rstmem/instret", instret, 32'(exp_ret));

    // Illegal opcode traps after DECODE; later fetch acks are ignored.
    opcode = 7'b1111111; mif.i_mem_ack = 1'b1;
    #1;
    chk("illegal/fetch", 32'(ctl()), 32'(C_F_ACK));
    step();
    chk("illegal/decode", 32'(ctl()), 32'(C_IDLE));
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("illegal/trap%0d", k), 32'(ctl()), 32'(C_TRAP));
      step();
    end
    chk("illegal/instret", instret, 32'(exp_ret));

    // Watchdog: fetch never acked, trap appears in cycle 16 after release.
    rst = 1'b1; mif.i_mem_ack = 1'b0;
    step();
    rst = 1'b0;
    #1;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("wdog/c%0d", c), 32'(ctl()), (c < 16) ? 32'(C_F_WAIT) : 32'(C_TRAP));
      step();
    end
    chk("wdog/sticky", 32'(ctl()), 32'(C_TRAP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
